dino_sprite_render: RTL and testbench

//  - Upstream address generator and pixel gate for the 8x8 dino sprite ROM.
//  - Compares the VGA beam position (hpos/vpos) with the dino's on-screen position.
//  - Drives the 6-bit ROM index {row[2:0], col[2:0]} and gates the returned colour bit

---
 rtl/dino_pkg.sv | 8 +
 rtl/dino_box_hit.sv | 26 ++
 rtl/dino_sprite_render.sv | 71 +++++++
 tb/tb_dino_sprite_render.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: shared sprite ROM geometry and screen coordinate types for the dino stages.
package dino_pkg;
  localparam int COORD_W      = 10;
  localparam int SPRITE_DIM   = 8;
  localparam int SPRITE_IDX_W = 3;
  localparam int ROM_ADDR_W   = 6;
  typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/dino_box_hit.sv
// dino_box_hit: combinational beam-vs-sprite box test with row/col ROM indices.
// Box is evaluated unsigned, so sprites near the right/bottom edge clip instead of wrapping.
module dino_box_hit
  import dino_pkg::*;
#(
  parameter int COORD_W    = dino_pkg::COORD_W,
  parameter int SCALE_LOG2 = 2
) (
  input  logic [COORD_W-1:0]      pos_x_i,
  input  logic [COORD_W-1:0]      pos_y_i,
  input  logic [COORD_W-1:0]      hpos_i,
  input  logic [COORD_W-1:0]      vpos_i,
  output logic                    hit_o,
  output logic [SPRITE_IDX_W-1:0] row_o,
  output logic [SPRITE_IDX_W-1:0] col_o
);
  localparam logic [COORD_W:0] BOX = (COORD_W+1)'(SPRITE_DIM << SCALE_LOG2);
  logic [COORD_W:0] dx, dy;
  always_comb begin
    dx = {1'b0, hpos_i} - {1'b0, pos_x_i};
    dy = {1'b0, vpos_i} - {1'b0, pos_y_i};
    hit_o = !dx[COORD_W] && (dx < BOX) && !dy[COORD_W] && (dy < BOX);
    row_o = dy[SCALE_LOG2 +: SPRITE_IDX_W];
    col_o = dx[SCALE_LOG2 +: SPRITE_IDX_W];
  end
endmodule

// File: rtl/dino_sprite_render.sv
// dino_sprite_render: frame-latched dino position, ROM address generation and pixel gating.
// Define DINO_FLIP_EN to add i_flip (latched with the position) for a mirrored sprite.
module dino_sprite_render
  import dino_pkg::*;
#(
  parameter int SCALE_LOG2 = 2,
  parameter int COORD_W    = dino_pkg::COORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COORD_W-1:0]    i_hpos,
  input  logic [COORD_W-1:0]    i_vpos,
  input  logic                  i_frame_start,
  input  logic [COORD_W-1:0]    i_dino_x,
  input  logic [COORD_W-1:0]    i_dino_y,
`ifdef DINO_FLIP_EN
  input  logic                  i_flip,
`endif
  output logic [ROM_ADDR_W-1:0] o_rom_counter,
  input  logic                  i_sprite_color,
  output logic                  o_in_sprite,
  output logic                  o_pixel_on
);
  logic [COORD_W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic                  flip_q, flip_d;
  logic                  hit, hit_q;
  logic [ROM_ADDR_W-1:0] rom_d;
  logic [SPRITE_IDX_W-1:0] row, col;

  dino_box_hit #(.COORD_W(COORD_W), .SCALE_LOG2(SCALE_LOG2)) u_hit (
    .pos_x_i(pos_x_q),
    .pos_y_i(pos_y_q),
    .hpos_i (i_hpos),
    .vpos_i (i_vpos),
    .hit_o  (hit),
    .row_o  (row),
    .col_o  (col)
  );

  // The current pixel still sees the old position; the new one lands on the next cycle.
  always_comb begin
    pos_x_d = i_frame_start ? i_dino_x : pos_x_q;
    pos_y_d = i_frame_start ? i_dino_y : pos_y_q;
`ifdef DINO_FLIP_EN
    flip_d = i_frame_start ? i_flip : flip_q;
`else
    flip_d = 1'b0;
`endif
    rom_d = hit ? {row, flip_q ? ~col : col} : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      flip_q        <= 1'b0;
      o_rom_counter <= '0;
      hit_q         <= 1'b0;
      o_in_sprite   <= 1'b0;
      o_pixel_on    <= 1'b0;
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      flip_q        <= flip_d;
      o_rom_counter <= rom_d;
      hit_q         <= hit;
      o_in_sprite   <= hit_q;
      o_pixel_on    <= hit_q & i_sprite_color;
    end
  end
endmodule

// File: tb/tb_dino_sprite_render.sv
// tb_dino_sprite_render: directed and random beam sweeps checked against an arithmetic model.
module tb_dino_sprite_render;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos, vpos, dino_x, dino_y;
  logic       fs, flip, color, ins, pix;
  logic [5:0] rc;
  logic [63:0] rom;
  logic [7:0]  row0;

  int total = 0, bad = 0;
  int mx = 0, my = 0;
  bit mf = 0, ph = 0, pp = 0;

  always #5 clk = ~clk;
  assign color = rom[rc];

  dino_sprite_render dut (
    .clk           (clk),
    .rst           (rst),
    .i_hpos        (hpos),
    .i_vpos        (vpos),
    .i_frame_start (fs),
    .i_dino_x      (dino_x),
    .i_dino_y      (dino_y),
`ifdef DINO_FLIP_EN
    .i_flip        (flip),
`endif
    .o_rom_counter (rc),
    .i_sprite_color(color),
    .o_in_sprite   (ins),
    .o_pixel_on    (pix)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One beam pixel per cycle; the model derives hit/index from screen arithmetic.
  task automatic step(int h, int v, bit f = 0, int x = 0, int y = 0, bit fl = 0);
    int ddx, ddy, erc;
    bit eh;
    hpos = h[9:0]; vpos = v[9:0]; fs = f;
    dino_x = x[9:0]; dino_y = y[9:0]; flip = fl;
    @(posedge clk); #1;
    ddx = h - mx;
    ddy = v - my;
    eh = ddx >= 0 && ddx < 32 && ddy >= 0 && ddy < 32;
    erc = eh ? (ddy / 4) * 8 + (mf ? 7 - ddx / 4 : ddx / 4) : 0;
    chk("rom_counter", {26'd0, rc}, erc);
    chk("in_sprite", {31'd0, ins}, {31'd0, ph});
    chk("pixel_on", {31'd0, pix}, {31'd0, pp});
    ph = eh;
    pp = eh && rom[erc];
    if (f) begin
      mx = x; my = y;
`ifdef DINO_FLIP_EN
      mf = fl;
`endif
    end
  endtask

  initial begin
    row0 = 8'b01110000;
    rom = {$urandom, $urandom};
    for (int c = 0; c < 8; c++) rom[c] = row0[7-c];
    rst = 1'b1; hpos = 0; vpos = 0; fs = 0; dino_x = 0; dino_y = 0; flip = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rc", {26'd0, rc}, 0);
    chk("rst_in", {31'd0, ins}, 0);
    chk("rst_pix", {31'd0, pix}, 0);
    rst = 1'b0;

    // basic draw at (100,50)
    step(0, 0, 1, 100, 50);
    step(100, 50);
    chk("corner_rc", {26'd0, rc}, 0);
    step(131, 81);
    chk("far_corner_rc", {26'd0, rc}, 63);
    step(132, 50);
    step(0, 0);
    step(0, 0);

    // colour sweep across row 0
    for (int h = 96; h < 136; h++) step(h, 50);
    step(0, 0);
    step(0, 0);

    // x request changes without frame_start: sprite stays at 100
    for (int h = 98; h < 134; h += 3) step(h, 52, 0, 200, 50);
    step(110, 55, 1, 200, 50);
    for (int h = 96; h < 236; h += 5) step(h, 55);
    step(0, 0);

    // right-edge clip, no wrap
    step(0, 0, 1, 1020, 50);
    for (int h = 1020; h < 1024; h++) step(h, 50);
    for (int h = 0; h < 28; h++) step(h, 50);
    step(0, 0);
    step(0, 0);

`ifdef DINO_FLIP_EN
    step(0, 0, 1, 100, 50, 1);
    step(100, 50);
    chk("flip_col", {29'd0, rc[2:0]}, 7);
    step(0, 0, 1, 100, 50, 0);
    step(100, 50);
    chk("noflip_col", {29'd0, rc[2:0]}, 0);
    step(0, 0);
`endif

    // random beams around randomly placed sprites
    for (int i = 0; i < 400; i++) begin
      int nx, ny;
      bit nf;
      nf = ($urandom_range(0, 15) == 0);
      nx = $urandom_range(0, 1023);
      ny = $urandom_range(0, 479);
      step((mx + $urandom_range(0, 40) + 1020) % 1024, (my + $urandom_range(0, 40) + 1020) % 1024,
           nf, nx, ny, 1'($urandom_range(0, 1)));
    end

    // async reset while drawing a lit pixel
    step(0, 0, 1, 100, 50);
    step(104, 50);
    step(104, 50);
    step(104, 50);
    chk("pix_before_rst", {31'd0, pix}, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rc", {26'd0, rc}, 0);
    chk("midrst_in", {31'd0, ins}, 0);
    chk("midrst_pix", {31'd0, pix}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mx = 0; my = 0; mf = 0; ph = 0; pp = 0;
    step(4, 4);
    chk("post_rst_rc", {26'd0, rc}, 9);
    step(100, 50);
    step(31, 31);
    step(0, 0);
    step(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
